// File: rtl/demux_collect.sv
// demux_collect: routes serial beats into a 4-lane frame and presents it with a valid/ready handshake.
// Optional build macro DEMUX_AUTOSEL_EN replaces the s lane select with an internal round-robin lane pointer.
module demux_collect #(
    parameter int TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       y,
    input  logic [1:0] s,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [3:0] d,
    output logic [3:0] mask,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       dup_err
);

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        PRESENT = 1'b1
    } state_t;

    // The flush fires on the edge where the idle count steps onto TIMEOUT.
    localparam logic       TO_EN   = (TIMEOUT != 0);
    localparam logic [7:0] TO_LAST = (TIMEOUT == 0) ? 8'd0 : 8'(TIMEOUT - 1);

    state_t     state_r;
    state_t     state_nxt_s;
    logic [3:0] d_r;
    logic [3:0] mask_r;
    logic [7:0] cnt_r;
    logic       dup_err_r;

    logic [1:0] lane_s;
    logic [3:0] lane_oh_s;
    logic       ready_s;
    logic       accept_s;
    logic       full_s;
    logic       flush_s;
    logic       handshake_s;
    logic       dup_s;

`ifdef DEMUX_AUTOSEL_EN
    logic [1:0] ptr_r;
    logic       unused_s;

    assign unused_s = ^s;
    assign lane_s   = ptr_r;
    assign dup_s    = 1'b0;

    // Round-robin lane pointer, restarted at every frame boundary.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_r <= 2'd0;
        end else if (handshake_s || flush_s) begin
            ptr_r <= 2'd0;
        end else if (accept_s) begin
            ptr_r <= ptr_r + 2'd1;
        end else begin
            ptr_r <= ptr_r;
        end
    end
`else
    assign lane_s = s;
    assign dup_s  = mask_r[lane_s];
`endif

    // in_ready depends only on registered state and reset, never on out_ready.
    assign ready_s     = rst_n & (state_r == COLLECT);
    assign accept_s    = in_valid & ready_s;
    assign lane_oh_s   = 4'b0001 << lane_s;
    assign full_s      = accept_s & ((mask_r | lane_oh_s) == 4'b1111);
    assign flush_s     = TO_EN & (state_r == COLLECT) & ~accept_s
                         & (mask_r != 4'b0000) & (cnt_r == TO_LAST);
    assign handshake_s = (state_r == PRESENT) & out_ready;

    assign in_ready  = ready_s;
    assign out_valid = (state_r == PRESENT);
    assign d         = d_r;
    assign mask      = mask_r;
    assign dup_err   = dup_err_r;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= COLLECT;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            COLLECT: begin
                if (full_s || flush_s) begin
                    state_nxt_s = PRESENT;
                end else begin
                    state_nxt_s = COLLECT;
                end
            end
            PRESENT: begin
                if (out_ready) begin
                    state_nxt_s = COLLECT;
                end else begin
                    state_nxt_s = PRESENT;
                end
            end
            default: state_nxt_s = COLLECT;
        endcase
    end

    // Frame data and lane-written mask.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            d_r    <= 4'b0000;
            mask_r <= 4'b0000;
        end else if (handshake_s) begin
            d_r    <= 4'b0000;
            mask_r <= 4'b0000;
        end else if (accept_s) begin
            d_r    <= (d_r & ~lane_oh_s) | ({4{y}} & lane_oh_s);
            mask_r <= mask_r | lane_oh_s;
        end else begin
            d_r    <= d_r;
            mask_r <= mask_r;
        end
    end

    // Saturating idle counter; only meaningful while a partial frame is held.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r <= 8'd0;
        end else if (accept_s || handshake_s || (mask_r == 4'b0000)) begin
            cnt_r <= 8'd0;
        end else if ((state_r == COLLECT) && (cnt_r != 8'hFF)) begin
            cnt_r <= cnt_r + 8'd1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Duplicate-lane pulse, one cycle after the offending beat.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dup_err_r <= 1'b0;
        end else begin
            dup_err_r <= accept_s & dup_s;
        end
    end

endmodule

// File: tb/tb_demux_collect.sv
// Scoreboard bench for demux_collect: stimulus pushes expected frames, a monitor checks each handshake.
module tb_demux_collect;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       y, in_valid, out_ready;
    logic [1:0] s;
    logic       in_ready, out_valid, dup_err;
    logic [3:0] d, mask;

    logic       y0, in_valid0, out_ready0;
    logic [1:0] s0;
    logic       in_ready0, out_valid0, dup_err0;
    logic [3:0] d0, mask0;

    logic [7:0] exp_q[$];
    int         tests  = 0;
    int         fails  = 0;
    int         popped = 0;

    demux_collect #(.TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n), .y(y), .s(s), .in_valid(in_valid),
        .in_ready(in_ready), .d(d), .mask(mask), .out_valid(out_valid),
        .out_ready(out_ready), .dup_err(dup_err)
    );

    demux_collect #(.TIMEOUT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .y(y0), .s(s0), .in_valid(in_valid0),
        .in_ready(in_ready0), .d(d0), .mask(mask0), .out_valid(out_valid0),
        .out_ready(out_ready0), .dup_err(dup_err0)
    );

    always #5 clk = ~clk;

    task automatic chk4(input string name, input logic [3:0] act, input logic [3:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chkn(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [1:0] ss, input logic yy);
        in_valid = 1'b1;
        s        = ss;
        y        = yy;
        cyc();
    endtask

    // Monitor: every handshake must match the oldest expected frame.
    always @(negedge clk) begin
        logic [7:0] e;
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_frame: got d=%b mask=%b expected none", d, mask);
            end else begin
                e = exp_q.pop_front();
                chk4("frame_d", d, e[7:4]);
                chk4("frame_mask", mask, e[3:0]);
                popped++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int seen;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; s = 2'd0; y = 1'b0;
        in_valid0 = 1'b0; out_ready0 = 1'b0; s0 = 2'd0; y0 = 1'b0;
        cyc();
        cyc();
        chk4("rst_in_ready", {3'b0, in_ready}, 4'd0);
        chk4("rst_out_valid", {3'b0, out_valid}, 4'd0);
        chk4("rst_d", d, 4'b0000);
        chk4("rst_mask", mask, 4'b0000);
        chk4("rst_dup", {3'b0, dup_err}, 4'd0);
        rst_n = 1'b1;
        #1;
        chk4("rel_in_ready", {3'b0, in_ready}, 4'd1);

`ifdef DEMUX_AUTOSEL_EN
        seen = 0;
        out_ready = 1'b1;
        exp_q.push_back({4'b1001, 4'b1111});
        beat(2'd3, 1'b1); seen += int'(dup_err);
        beat(2'd3, 1'b0); seen += int'(dup_err);
        beat(2'd3, 1'b0); seen += int'(dup_err);
        chk4("auto_pre_valid", {3'b0, out_valid}, 4'd0);
        beat(2'd3, 1'b1); seen += int'(dup_err);
        in_valid = 1'b0;
        chk4("auto_valid", {3'b0, out_valid}, 4'd1);
        cyc(); seen += int'(dup_err);
        chkn("auto_no_dup", seen, 0);
        exp_q.push_back({4'b0110, 4'b1111});
        beat(2'd0, 1'b0); beat(2'd0, 1'b1); beat(2'd0, 1'b1); beat(2'd0, 1'b0);
        in_valid = 1'b0;
        cyc();
        out_ready = 1'b0;
        exp_q.push_back({4'b0001, 4'b0001});
        beat(2'd2, 1'b1);
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) cyc();
        chk4("auto_flush_valid", {3'b0, out_valid}, 4'd1);
        out_ready = 1'b1;
        cyc();
        exp_q.push_back({4'b0011, 4'b1111});
        beat(2'd1, 1'b1); beat(2'd1, 1'b1); beat(2'd1, 1'b0); beat(2'd1, 1'b0);
        in_valid = 1'b0;
        cyc();
        cyc();
        chkn("frames_seen", popped, 4);
`else
        // Basic frame, 1-cycle latency.
        out_ready = 1'b1;
        exp_q.push_back({4'b1101, 4'b1111});
        beat(2'd0, 1'b1); beat(2'd1, 1'b0); beat(2'd2, 1'b1);
        chk4("t1_pre_valid", {3'b0, out_valid}, 4'd0);
        beat(2'd3, 1'b1);
        in_valid = 1'b0;
        chk4("t1_valid", {3'b0, out_valid}, 4'd1);
        chk4("t1_in_ready", {3'b0, in_ready}, 4'd0);
        chk4("t1_d", d, 4'b1101);
        cyc();
        chk4("t1_back_valid", {3'b0, out_valid}, 4'd0);
        chk4("t1_back_mask", mask, 4'b0000);
        chk4("t1_back_d", d, 4'b0000);
        chk4("t1_back_ready", {3'b0, in_ready}, 4'd1);

        // Duplicate lane.
        beat(2'd2, 1'b1);
        chk4("t2_dup0", {3'b0, dup_err}, 4'd0);
        chk4("t2_mask0", mask, 4'b0100);
        beat(2'd2, 1'b0);
        in_valid = 1'b0;
        chk4("t2_dup1", {3'b0, dup_err}, 4'd1);
        chk4("t2_d", d, 4'b0000);
        chk4("t2_mask", mask, 4'b0100);
        cyc();
        chk4("t2_dup_clear", {3'b0, dup_err}, 4'd0);
        exp_q.push_back({4'b0011, 4'b1111});
        beat(2'd0, 1'b1); beat(2'd1, 1'b1); beat(2'd3, 1'b0);
        in_valid = 1'b0;
        cyc();

        // Partial flush at TIMEOUT=4.
        out_ready = 1'b0;
        exp_q.push_back({4'b0010, 4'b0010});
        beat(2'd1, 1'b1);
        in_valid = 1'b0;
        seen = 0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            seen += int'(out_valid);
        end
        chkn("t3_early_flush", seen, 0);
        cyc();
        chk4("t3_valid", {3'b0, out_valid}, 4'd1);
        chk4("t3_d", d, 4'b0010);
        chk4("t3_mask", mask, 4'b0010);
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        chk4("t3_back_valid", {3'b0, out_valid}, 4'd0);

        // TIMEOUT=0 never flushes.
        in_valid0 = 1'b1; s0 = 2'd1; y0 = 1'b1;
        cyc();
        in_valid0 = 1'b0;
        seen = 0;
        for (int i = 0; i < 300; i++) begin
            cyc();
            seen += int'(out_valid0);
        end
        chkn("t3_no_flush", seen, 0);
        chk4("t3_nf_mask", mask0, 4'b0010);
        chk4("t3_nf_d", d0, 4'b0010);

        // Back-pressure with a pending beat.
        exp_q.push_back({4'b1010, 4'b1111});
        beat(2'd0, 1'b0); beat(2'd1, 1'b1); beat(2'd2, 1'b0); beat(2'd3, 1'b1);
        s = 2'd0; y = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk4("t4_in_ready", {3'b0, in_ready}, 4'd0);
            chk4("t4_d_hold", d, 4'b1010);
            chk4("t4_mask_hold", mask, 4'b1111);
        end
        exp_q.push_back({4'b0101, 4'b1111});
        out_ready = 1'b1;
        cyc();
        chk4("t4_after_mask", mask, 4'b0000);
        chk4("t4_after_ready", {3'b0, in_ready}, 4'd1);
        cyc();
        chk4("t4_kept_mask", mask, 4'b0001);
        chk4("t4_kept_d", d, 4'b0001);
        beat(2'd1, 1'b0); beat(2'd2, 1'b1); beat(2'd3, 1'b0);
        in_valid = 1'b0;
        chk4("t4_valid", {3'b0, out_valid}, 4'd1);
        cyc();

        // Reset mid-frame.
        beat(2'd0, 1'b1); beat(2'd1, 1'b1); beat(2'd2, 1'b1);
        in_valid = 1'b0;
        rst_n = 1'b0;
        cyc();
        chk4("t5_d", d, 4'b0000);
        chk4("t5_mask", mask, 4'b0000);
        chk4("t5_valid", {3'b0, out_valid}, 4'd0);
        chk4("t5_dup", {3'b0, dup_err}, 4'd0);
        chk4("t5_in_ready", {3'b0, in_ready}, 4'd0);
        rst_n = 1'b1;
        #1;
        chk4("t5_rel_ready", {3'b0, in_ready}, 4'd1);
        exp_q.push_back({4'b1010, 4'b1111});
        beat(2'd3, 1'b1); beat(2'd2, 1'b0); beat(2'd1, 1'b1); beat(2'd0, 1'b0);
        in_valid = 1'b0;
        cyc();
        cyc();
        chkn("frames_seen", popped, 6);
`endif
        chkn("queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
